seq101_frame_tx: RTL
====================

# seq101_frame_tx

Serial frame transmitter that drives the single-bit line read by the team's "101" sequence-detector FSMs. Each accepted parallel word is sent as a frame: the 3-bit sync marker 1-0-1, then the word MSB first, then a guaranteed run of idle zeros. The downstream detector asserts on the marker's final 1, so frame alignment is recovered at the receiving end. Upstream logic supplies words over a valid/ready handshake.

## Interface
- WIDTH, 8, payload bits per frame; legal range 1..32.
- IDLE_MIN, 2, idle (0) bit-times after each frame before the next frame may be accepted; legal range 1..15.

- clk  input  1  rising-edge clock; one bit-time per cycle.
- areset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has a word to send.
- in_data  input  WIDTH  word to send; sampled only on handshake.
- in_ready  output  1  block can accept a word this cycle.
- out  output  1  serial line; 0 when idle.
- busy  output  1  high while marker or payload bits are on out.
- frame_start  output  1  one-cycle pulse while the first marker bit is on out.
- frame_done  output  1  one-cycle pulse while the last payload bit is on out.

## Operation
- The block has one clock, clk. Reset areset_n is asynchronous and active-low.
- States and the value on out in each:
  - GAP: out=0.
  - IDLE: out=0.
  - SYNC_H1: out=1.
  - SYNC_L: out=0.
  - SYNC_H2: out=1.
  - DATA: out=shift register MSB.
- Transitions:
  - IDLE to SYNC_H1 on handshake (in_valid & in_ready); otherwise stay in IDLE.
  - SYNC_H1 to SYNC_L to SYNC_H2 to DATA, unconditionally.
  - DATA lasts exactly WIDTH cycles, tracked by a bit counter; the shift register shifts left by 1 each DATA cycle.
  - DATA to GAP after the last bit.
  - GAP lasts exactly IDLE_MIN cycles, tracked by a gap counter, then goes to IDLE.
- Handshake:
  - in_ready=1 only in IDLE and never while areset_n=0. It does not depend on in_valid.
  - On handshake, in_data loads into a WIDTH-bit shift register.
  - in_data and in_valid are ignored in every other state.
- Outputs:
  - busy=1 in SYNC_H1, SYNC_L, SYNC_H2 and DATA.
  - frame_start=1 in SYNC_H1 only.
  - frame_done=1 in the DATA cycle with bit counter = WIDTH-1.
- All outputs decode from state and counter registers only: no input-to-output combinational paths except areset_n gating in_ready.
- Payload is not bit-stuffed. Payload content may itself contain 1-0-1; receivers rely on frame timing, not marker uniqueness.
- Counter widths are sized from the parameters: the bit counter is clog2(WIDTH)+1 bits and the gap counter is 4 bits. Both count up and clear on state entry.

## Timing
- Reset values, held while areset_n=0:
  - state=GAP with gap counter 0.
  - out=0, in_ready=0, busy=0, frame_start=0, frame_done=0.
- After reset release, out stays 0 for IDLE_MIN cycles (GAP), then in_ready rises.
- Handshake at edge k: out=1 (SYNC_H1) in cycle k+1. Payload MSB appears in cycle k+4 and payload LSB in cycle k+3+WIDTH.
- Frame length is 3+WIDTH cycles. Minimum handshake-to-handshake period is 4+WIDTH+IDLE_MIN cycles (one IDLE cycle is included).
- If in_valid is held continuously, words are accepted at exactly that period with no extra bubbles.
- Reset mid-frame: all outputs go to their reset values immediately (asynchronously) and the frame is abandoned, with no partial completion. Restart is via GAP.
- WIDTH=1: DATA lasts one cycle, and frame_start and frame_done fall in different cycles. When WIDTH=1 the frame_done cycle is the single DATA cycle.

## Test plan
- Reset: assert areset_n=0 mid-idle, then release. Required: out=0, busy=0 and in_ready=0 during reset and for 2 cycles after release (IDLE_MIN=2); in_ready=1 on the 3rd cycle.
- Single frame, WIDTH=8, in_data=8'hA5 at edge k. Required:
  - out over cycles k+1..k+11 = 1,0,1,1,0,1,0,0,1,0,1.
  - frame_start at k+1, frame_done at k+11.
  - out=0 at k+12 and k+13, in_ready=1 at k+14.
- Back-to-back: in_valid held high with 8'h00 then 8'hFF. Required: second frame_start exactly 14 cycles after the first; second payload is eight 1s.
- Data stability: change in_data every cycle during a frame of 8'h3C. Required: transmitted payload is 0,0,1,1,1,1,0,0 and in_ready=0 throughout.
- Reset mid-frame: assert areset_n=0 during payload bit 3. Required: out, busy and in_ready are 0 at once; after release, 2 gap cycles, then a new 8'h81 frame sends 1,0,1,1,0,0,0,0,0,0,1 with no residue of the aborted word.
- Idle: in_valid=0 for 50 cycles. Required: out=0, busy=0, frame_start never pulses, in_ready stays 1.

Source files
------------

// File: rtl/seq101_frame_tx_if.sv
// Word-in / serial-out bundle for the 101-marker frame transmitter.
// Latency: none (wires only).
// Backpressure: in_ready qualifies in_valid; a word moves when both are high.
interface seq101_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out;
    logic             busy;
    logic             frame_start;
    logic             frame_done;

    // Upstream word source plus whoever observes the serial line.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out,
        input  busy,
        input  frame_start,
        input  frame_done
    );

    // The transmitter itself.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out,
        output busy,
        output frame_start,
        output frame_done
    );
endinterface

// File: rtl/seq101_frame_tx.sv
// Serialises each accepted word as marker 1-0-1, payload MSB first, then IDLE_MIN zeros.
// Latency: marker first bit on out the cycle after the handshake; frame is 3+WIDTH cycles.
// Backpressure: in_ready only in IDLE, so words are taken at most once per 4+WIDTH+IDLE_MIN cycles.
module seq101_frame_tx #(
    parameter int WIDTH    = 8,
    parameter int IDLE_MIN = 2
) (
    input  logic clk,
    input  logic areset_n,
    seq101_frame_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] BIT_ONE  = CW'(1);
    localparam logic [3:0]    GAP_LAST = 4'(IDLE_MIN - 1);

    typedef enum logic [2:0] {
        GAP,
        IDLE,
        SYNC_H1,
        SYNC_L,
        SYNC_H2,
        DATA
    } state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;

    logic out_r;
    logic busy_r;
    logic start_r;
    logic done_r;
    logic rdy_r;

    // Next MSB to present once the current payload bit has been sent.
    assign shifted = shreg << 1;

    // Frame sequencer; every output is registered alongside the state it belongs to,
    // so each output register already holds the value for the state being entered.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= GAP;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            out_r   <= 1'b0;
            busy_r  <= 1'b0;
            start_r <= 1'b0;
            done_r  <= 1'b0;
            rdy_r   <= 1'b0;
        end else begin
            start_r <= 1'b0;
            done_r  <= 1'b0;
            unique case (state)
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        rdy_r <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                IDLE: begin
                    if (bus.in_valid) begin
                        state   <= SYNC_H1;
                        shreg   <= bus.in_data;
                        rdy_r   <= 1'b0;
                        out_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        start_r <= 1'b1;
                    end
                end
                SYNC_H1: begin
                    state <= SYNC_L;
                    out_r <= 1'b0;
                end
                SYNC_L: begin
                    state <= SYNC_H2;
                    out_r <= 1'b1;
                end
                SYNC_H2: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    out_r   <= shreg[WIDTH-1];
                    // A one-bit payload finishes in its first DATA cycle.
                    done_r  <= (WIDTH == 1);
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                        out_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_ONE;
                        shreg   <= shifted;
                        out_r   <= shifted[WIDTH-1];
                        done_r  <= ((bit_cnt + BIT_ONE) == BIT_LAST);
                    end
                end
                default: begin
                    state   <= GAP;
                    gap_cnt <= '0;
                    out_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    rdy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Ready is forced low the instant reset asserts, independent of the clock.
    assign bus.in_ready    = rdy_r & areset_n;
    assign bus.out         = out_r;
    assign bus.busy        = busy_r;
    assign bus.frame_start = start_r;
    assign bus.frame_done  = done_r;
endmodule
